// File: rtl/write_ptr_flags.sv
// Write-side pointer and flag generator for an async FIFO (wclk domain).
// Tracks binary/Gray write pointers and produces full, almost-full, fill level and overflow.
module write_ptr_flags #(
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                wclk,
  input  logic                w_rst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr_sync,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic                ovf_clr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                wafull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  localparam int unsigned PtrW = ADDRSIZE + 1;

  logic [PtrW-1:0] wbin_q, wbin_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] wlevel_q, wlevel_d;
  logic            wfull_q, wfull_d;
  logic            wafull_q, wafull_d;
  logic            wovf_q, wovf_d;
  logic [PtrW-1:0] rbin;
  logic [PtrW-1:0] rptr_full_cmp;

  assign wen = winc & ~wfull_q;

  always_comb begin
    rbin = '0;
    rbin[PtrW-1] = rptr_sync[PtrW-1];
    for (int i = PtrW - 2; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ rptr_sync[i];
    end
  end

  // Full when the write pointer has lapped the read pointer by exactly one DEPTH.
  assign rptr_full_cmp = {~rptr_sync[ADDRSIZE:ADDRSIZE-1], rptr_sync[ADDRSIZE-2:0]};

  always_comb begin
    wbin_d   = wbin_q + {{ADDRSIZE{1'b0}}, wen};
    wptr_d   = (wbin_d >> 1) ^ wbin_d;
    wlevel_d = wbin_d - rbin;
    wfull_d  = (wptr_d == rptr_full_cmp);
    wafull_d = (wlevel_d >= afull_thresh);
    wovf_d   = wovf_q;
    if (winc && wfull_q) begin
      wovf_d = 1'b1;
    end else if (ovf_clr) begin
      wovf_d = 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    if (w_rst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr  = wbin_q[ADDRSIZE-1:0];
  assign wptr   = wptr_q;
  assign wfull  = wfull_q;
  assign wafull = wafull_q;
  assign wlevel = wlevel_q;
  assign wovf   = wovf_q;

endmodule

// File: tb/tb_write_ptr_flags.sv
// Directed self-checking bench for write_ptr_flags with ADDRSIZE=4 (DEPTH=16).
module tb_write_ptr_flags;

  logic       wclk = 1'b0;
  logic       w_rst;
  logic       winc;
  logic [4:0] rptr_sync;
  logic [4:0] afull_thresh;
  logic       ovf_clr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       wafull;
  logic [4:0] wlevel;
  logic       wovf;

  int n_checks = 0;
  int n_fail   = 0;

  write_ptr_flags #(.ADDRSIZE(4)) dut (
    .wclk         (wclk),
    .w_rst        (w_rst),
    .winc         (winc),
    .rptr_sync    (rptr_sync),
    .afull_thresh (afull_thresh),
    .ovf_clr      (ovf_clr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .wafull       (wafull),
    .wlevel       (wlevel),
    .wovf         (wovf)
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    w_rst = 1'b1;
    winc = 1'b0;
    ovf_clr = 1'b0;
    rptr_sync = '0;
    tick();
    tick();
    w_rst = 1'b0;
  endtask

  logic [4:0] wb;
  logic [4:0] prev_wptr;

  initial begin
    afull_thresh = 5'd12;
    do_reset();
    check_eq("rst_wptr", wptr, 0);
    check_eq("rst_waddr", waddr, 0);
    check_eq("rst_wlevel", wlevel, 0);
    check_eq("rst_wfull", wfull, 0);
    check_eq("rst_wafull", wafull, 0);
    check_eq("rst_wovf", wovf, 0);

    // Almost-full threshold at 12
    winc = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    check_eq("af11_wafull", wafull, 0);
    check_eq("af11_wlevel", wlevel, 11);
    tick();
    check_eq("af12_wafull", wafull, 1);
    check_eq("af12_wlevel", wlevel, 12);
    check_eq("af12_wptr", wptr, 5'b01010);
    winc = 1'b0;
    rptr_sync = 5'b00110;
    tick();
    check_eq("rd4_wlevel", wlevel, 8);
    check_eq("rd4_wafull", wafull, 0);
    check_eq("rd4_wfull", wfull, 0);

    // Fill to full
    do_reset();
    winc = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check_eq("w15_wfull", wfull, 0);
    check_eq("w15_wlevel", wlevel, 15);
    tick();
    check_eq("w16_wfull", wfull, 1);
    check_eq("w16_wlevel", wlevel, 16);
    check_eq("w16_waddr", waddr, 0);
    check_eq("w16_wptr", wptr, 5'b11000);
    check_eq("w16_wovf", wovf, 0);
    #1;
    check_eq("full_wen", wen, 0);
    tick();
    check_eq("ovf_wovf", wovf, 1);
    check_eq("ovf_wptr", wptr, 5'b11000);
    check_eq("ovf_waddr", waddr, 0);
    check_eq("ovf_wlevel", wlevel, 16);
    check_eq("ovf_wfull", wfull, 1);
    winc = 1'b0;
    tick();
    check_eq("ovf_held", wovf, 1);
    ovf_clr = 1'b1;
    tick();
    check_eq("ovf_clr", wovf, 0);
    winc = 1'b1;
    tick();
    check_eq("ovf_set_wins", wovf, 1);
    ovf_clr = 1'b0;
    winc = 1'b0;
    tick();
    check_eq("full_sticky", wfull, 1);
    rptr_sync = gray(5'd1);
    tick();
    check_eq("rd1_wfull", wfull, 0);
    check_eq("rd1_wlevel", wlevel, 15);
    check_eq("rd1_wovf", wovf, 1);

    // 40 writes with read pointer trailing by two
    do_reset();
    winc = 1'b1;
    tick();
    tick();
    wb = 5'd2;
    check_eq("trk_start_lvl", wlevel, 2);
    for (int i = 0; i < 40; i++) begin
      prev_wptr = wptr;
      rptr_sync = gray(wb - 5'd1);
      #1;
      check_eq("trk_wen", wen, 1);
      tick();
      wb = wb + 5'd1;
      check_eq("trk_wlevel", wlevel, 2);
      check_eq("trk_wfull", wfull, 0);
      check_eq("trk_wptr", wptr, gray(wb));
      check_eq("trk_waddr", waddr, wb[3:0]);
      check_eq("trk_gray_step", $countones(wptr ^ prev_wptr), 1);
    end

    // Mid-stream reset with threshold zero
    afull_thresh = 5'd0;
    w_rst = 1'b1;
    tick();
    check_eq("mrst_wptr", wptr, 0);
    check_eq("mrst_waddr", waddr, 0);
    check_eq("mrst_wlevel", wlevel, 0);
    check_eq("mrst_wfull", wfull, 0);
    check_eq("mrst_wafull", wafull, 0);
    check_eq("mrst_wovf", wovf, 0);
    w_rst = 1'b0;
    winc = 1'b0;
    rptr_sync = '0;
    tick();
    check_eq("th0_wafull", wafull, 1);
    check_eq("th0_wlevel", wlevel, 0);

    // Threshold above depth never asserts
    afull_thresh = 5'd17;
    winc = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    check_eq("th17_wafull", wafull, 0);
    check_eq("th17_wfull", wfull, 1);
    check_eq("th17_wlevel", wlevel, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
